alu_slave_ctrl: RTL and testbench

//  Parametrised bus-slave front end for the ALU/DMAC subsystem. Maps the register set onto the s_* bus: control, interrupt, status, instruction push, result pop and an operand window.

---
 rtl/alu_slave_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_alu_slave_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_slave_ctrl.sv
// alu_slave_ctrl: bus-slave front end for the ALU/DMAC subsystem.
//  Decodes s_addr[7:0] onto the register set:
//   00 OPERATION_START ([0] start, [1] soft clear; reads 0)
//   01 INTERRUPT (bit0, W1C)   02 INTERRUPT_ENABLE   03 INSTRUCTION
//   04 RESULT (RO)             05 ALU_STATUS (RO)    10+i OPERAND_i
//  Ports:
//   clk, reset            clock / synchronous active-high reset
//   s_sel,s_wr,s_addr,s_din,s_dout  slave bus, s_dout registered
//   s_interrupt           INTERRUPT[0] & INTERRUPT_ENABLE[0], registered
//   o_din,o_push,o_wr_ack,o_wr_err  instruction FIFO push handshake
//   r_pop,r_dout,r_rd_ack,r_rd_err  result FIFO pop handshake
//   instruction_empty     instruction FIFO empty flag
//   we,wAddr,wData        ALU register-file write port
//   alu_begin,alu_done    ALU master start level / completion
//  Optional feature: define ALU_TIMEOUT_EN to enable the EXEC watchdog
//  (TIMEOUT_CYC cycles without alu_done -> FAULT).
module alu_slave_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int N_OPERAND   = 16,
  parameter int OPR_AW      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              s_interrupt,
  output logic [DATA_W-1:0] o_din,
  output logic              o_push,
  input  logic              o_wr_ack,
  input  logic              o_wr_err,
  output logic              r_pop,
  input  logic [DATA_W-1:0] r_dout,
  input  logic              r_rd_ack,
  input  logic              r_rd_err,
  input  logic              instruction_empty,
  output logic              we,
  output logic [OPR_AW-1:0] wAddr,
  output logic [DATA_W-1:0] wData,
  output logic              alu_begin,
  input  logic              alu_done
);
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_POP, S_DONE, S_FAULT} ctrl_st_t;
  typedef enum logic {P_IDLE, P_WAIT} push_st_t;

  ctrl_st_t r_st, w_nxt_st;
  push_st_t r_pst, w_nxt_pst;

  logic [DATA_W-1:0] r_opr [N_OPERAND];
  logic [DATA_W-1:0] r_ie, r_instr, r_result, w_rdata;
  logic [3:0]        r_sticky, w_sticky_nxt;   // ALU_STATUS[5:2]
  logic [1:0]        w_code;
  logic              r_irq, w_irq_nxt, w_irq_set;
  logic [7:0]        w_a;
  logic [3:0]        w_oi;
  logic w_wr, w_rd, w_start, w_sclr, w_w1c, w_instr_wr, w_opr_wr;
  logic w_push, w_drop, w_push_err, w_pop_err, w_tmo;
  logic w_unused;

  assign w_a        = s_addr[7:0];
  assign w_oi       = w_a[3:0];
  assign w_wr       = s_sel & s_wr;
  assign w_rd       = s_sel & ~s_wr;
  assign w_start    = w_wr && (w_a == 8'h00) && s_din[0];
  assign w_sclr     = w_wr && (w_a == 8'h00) && s_din[1];
  assign w_w1c      = w_wr && (w_a == 8'h01) && s_din[0];
  assign w_instr_wr = w_wr && (w_a == 8'h03);
  assign w_opr_wr   = w_wr && (w_a[7:4] == 4'h1) && (int'(w_oi) < N_OPERAND);
  assign w_push_err = (r_pst == P_WAIT) && o_wr_err;
  assign w_pop_err  = (r_st == S_POP) && r_rd_err;
  assign w_unused   = &{1'b0, s_addr[ADDR_W-1:8], (TIMEOUT_CYC > 0)};

`ifdef ALU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  // Held at zero outside EXEC, so every EXEC entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset || r_st != S_EXEC) r_tmo_cnt <= '0;
    else                         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end
  assign w_tmo = (r_st == S_EXEC) && !alu_done &&
                 (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st  <= S_IDLE;
      r_pst <= P_IDLE;
    end else begin
      r_st  <= w_nxt_st;
      r_pst <= w_nxt_pst;
    end
  end

  // Control FSM next state. A push error or soft clear overrides the
  // normal flow; soft clear has the last word.
  always_comb begin
    w_nxt_st = r_st;
    case (r_st)
      S_IDLE, S_DONE: if (w_start) w_nxt_st = instruction_empty ? S_FAULT : S_EXEC;
      S_EXEC: begin
        if (alu_done)   w_nxt_st = S_POP;
        else if (w_tmo) w_nxt_st = S_FAULT;
      end
      S_POP: begin
        if (r_rd_err)      w_nxt_st = S_FAULT;
        else if (r_rd_ack) w_nxt_st = S_DONE;
      end
      default: ;
    endcase
    if (w_push_err) w_nxt_st = S_FAULT;
    if (w_sclr)     w_nxt_st = S_IDLE;
  end

  // Push FSM: one push in flight; further INSTRUCTION writes are dropped
  // until the ack edge has passed. Soft clear does not touch it.
  always_comb begin
    w_nxt_pst = r_pst;
    w_push    = 1'b0;
    w_drop    = 1'b0;
    case (r_pst)
      P_IDLE: if (w_instr_wr) begin
        w_push    = 1'b1;
        w_nxt_pst = P_WAIT;
      end
      P_WAIT: begin
        w_drop = w_instr_wr;
        if (o_wr_ack) w_nxt_pst = P_IDLE;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_st)
      S_EXEC, S_POP: w_code = 2'b01;
      S_DONE:        w_code = 2'b10;
      S_FAULT:       w_code = 2'b11;
      default:       w_code = 2'b00;
    endcase
  end

  // Hardware set beats a same-cycle W1C; soft clear beats both.
  always_comb begin
    w_irq_set = ((w_nxt_st == S_DONE) || (w_nxt_st == S_FAULT)) && (w_nxt_st != r_st);
    w_irq_set = w_irq_set || w_push_err;
    if (w_sclr)         w_irq_nxt = 1'b0;
    else if (w_irq_set) w_irq_nxt = 1'b1;
    else if (w_w1c)     w_irq_nxt = 1'b0;
    else                w_irq_nxt = r_irq;
    w_sticky_nxt = w_sclr ? 4'b0 : (r_sticky | {w_tmo, w_drop, w_pop_err, w_push_err});
  end

  always_comb begin
    w_rdata = '0;
    case (w_a)
      8'h01: w_rdata[0]   = r_irq;
      8'h02: w_rdata      = r_ie;
      8'h03: w_rdata      = r_instr;
      8'h04: w_rdata      = r_result;
      8'h05: w_rdata[5:0] = {r_sticky, w_code};
      default: if (w_a[7:4] == 4'h1 && int'(w_oi) < N_OPERAND) w_rdata = r_opr[w_oi];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_OPERAND; i++) r_opr[i] <= '0;
      r_ie        <= '0;
      r_instr     <= '0;
      r_result    <= '0;
      r_sticky    <= '0;
      r_irq       <= 1'b0;
      s_dout      <= '0;
      s_interrupt <= 1'b0;
      o_din       <= '0;
      o_push      <= 1'b0;
      r_pop       <= 1'b0;
      we          <= 1'b0;
      wAddr       <= '0;
      wData       <= '0;
      alu_begin   <= 1'b0;
    end else begin
      we <= w_opr_wr;
      if (w_opr_wr) begin
        wAddr       <= OPR_AW'(w_oi);
        wData       <= s_din;
        r_opr[w_oi] <= s_din;
      end
      o_push <= w_push;
      if (w_push) begin
        o_din   <= s_din;
        r_instr <= s_din;
      end
      if (w_wr && w_a == 8'h02) r_ie <= s_din;
      alu_begin <= (w_nxt_st == S_EXEC);
      r_pop     <= (r_st == S_EXEC) && (w_nxt_st == S_POP);
      if (r_st == S_POP && w_nxt_st == S_DONE) r_result <= r_dout;
      r_irq       <= w_irq_nxt;
      // Uses next-cycle values so s_interrupt tracks INTERRUPT/IE exactly.
      s_interrupt <= w_irq_nxt & ((w_wr && w_a == 8'h02) ? s_din[0] : r_ie[0]);
      r_sticky    <= w_sticky_nxt;
      s_dout      <= w_rd ? w_rdata : '0;
    end
  end
endmodule

// File: tb/tb_alu_slave_ctrl.sv
module tb_alu_slave_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        s_sel = 0, s_wr = 0;
  logic [15:0] s_addr = '0;
  logic [31:0] s_din = '0, s_dout, o_din, r_dout = '0, wData;
  logic        s_interrupt, o_push, o_wr_ack = 0, o_wr_err = 0, r_pop;
  logic        r_rd_ack = 0, r_rd_err = 0, instruction_empty = 0, we;
  logic [3:0]  wAddr;
  logic        alu_begin, alu_done = 0;

  int n_cmp = 0, n_mis = 0;

  alu_slave_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
    .s_din(s_din), .s_dout(s_dout), .s_interrupt(s_interrupt), .o_din(o_din),
    .o_push(o_push), .o_wr_ack(o_wr_ack), .o_wr_err(o_wr_err), .r_pop(r_pop),
    .r_dout(r_dout), .r_rd_ack(r_rd_ack), .r_rd_err(r_rd_err),
    .instruction_empty(instruction_empty), .we(we), .wAddr(wAddr), .wData(wData),
    .alu_begin(alu_begin), .alu_done(alu_done));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic        exp_we;
    logic [3:0]  exp_wa;
    logic [31:0] exp_rd;
  } vec_t;

  // Reference state, kept at register-map level.
  logic [31:0] m_opr [16];
  logic [31:0] m_result;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    s_sel = 1; s_wr = 1; s_addr = a; s_din = d;
    step();
    s_sel = 0; s_wr = 0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    s_sel = 1; s_wr = 0; s_addr = a;
    step();
    d = s_dout;
    s_sel = 0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".s_dout"}, s_dout, 0);
    chk({nm, ".outs"}, {28'b0, s_interrupt, o_push, r_pop, we}, 0);
    chk({nm, ".o_din"}, o_din, 0);
    chk({nm, ".wAddr"}, {28'b0, wAddr}, 0);
    chk({nm, ".wData"}, wData, 0);
    chk({nm, ".alu_begin"}, {31'b0, alu_begin}, 0);
  endtask

  initial begin
    vec_t tbl [11];
    logic [31:0] d;

    for (int i = 0; i < 16; i++) m_opr[i] = '0;
    tbl[0]  = '{16'h0013, 1'b1, 32'hDEADBEEF, 1'b1, 4'd3,  32'hDEADBEEF};
    tbl[1]  = '{16'h0010, 1'b1, 32'h00000001, 1'b1, 4'd0,  32'h00000001};
    tbl[2]  = '{16'h001F, 1'b1, 32'hA5A5A5A5, 1'b1, 4'd15, 32'hA5A5A5A5};
    tbl[3]  = '{16'h0113, 1'b0, 32'h0,        1'b0, 4'd0,  32'hDEADBEEF};
    tbl[4]  = '{16'h0002, 1'b1, 32'hFFFF0001, 1'b0, 4'd0,  32'hFFFF0001};
    tbl[5]  = '{16'h0006, 1'b1, 32'h00001234, 1'b0, 4'd0,  32'h0};
    tbl[6]  = '{16'h0020, 1'b1, 32'h00005555, 1'b0, 4'd0,  32'h0};
    tbl[7]  = '{16'h0005, 1'b1, 32'h000000FF, 1'b0, 4'd0,  32'h0};
    tbl[8]  = '{16'h0004, 1'b1, 32'h000000FF, 1'b0, 4'd0,  32'h0};
    tbl[9]  = '{16'h0001, 1'b1, 32'h00000001, 1'b0, 4'd0,  32'h0};
    tbl[10] = '{16'h00FF, 1'b0, 32'h0,        1'b0, 4'd0,  32'h0};

    // Reset held for two cycles
    reset = 1; step(); step();
    chk_all_zero("reset");
    reset = 0;
    rd(16'h0005, d); chk("reset.status", d, 32'h0);

    // Table: register writes and readback
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].addr, tbl[i].wd);
        chk($sformatf("tbl%0d.we", i), {31'b0, we}, {31'b0, tbl[i].exp_we});
        if (tbl[i].exp_we) begin
          chk($sformatf("tbl%0d.wAddr", i), {28'b0, wAddr}, {28'b0, tbl[i].exp_wa});
          chk($sformatf("tbl%0d.wData", i), wData, tbl[i].wd);
          m_opr[tbl[i].exp_wa] = tbl[i].wd;
        end
      end
      rd(tbl[i].addr, d);
      chk($sformatf("tbl%0d.rd", i), d, tbl[i].exp_rd);
      chk($sformatf("tbl%0d.we_pulse", i), {31'b0, we}, 0);
    end
    step();
    chk("idle.s_dout", s_dout, 0);

    // Instruction push with a drop while waiting for ack
    wr(16'h0003, 32'h123);
    chk("push1.o_push", {31'b0, o_push}, 1);
    chk("push1.o_din", o_din, 32'h123);
    wr(16'h0003, 32'h456);
    chk("push2.o_push", {31'b0, o_push}, 0);
    chk("push2.o_din", o_din, 32'h123);
    step();
    o_wr_ack = 1; step(); o_wr_ack = 0;
    chk("push.ack_no_push", {31'b0, o_push}, 0);
    rd(16'h0005, d); chk("push.status_drop", d, 32'h10);
    rd(16'h0003, d); chk("push.instr", d, 32'h123);
    wr(16'h0003, 32'hA);
    chk("push3.o_push", {31'b0, o_push}, 1);
    o_wr_ack = 1; wr(16'h0003, 32'hB); o_wr_ack = 0;
    chk("push_ackcyc.dropped", {31'b0, o_push}, 0);
    wr(16'h0003, 32'hC);
    chk("push4.o_push", {31'b0, o_push}, 1);
    chk("push4.o_din", o_din, 32'hC);
    o_wr_ack = 1; step(); o_wr_ack = 0;
    wr(16'h0000, 32'h2);
    rd(16'h0005, d); chk("sclr.status", d, 32'h0);

    // Push error
    wr(16'h0003, 32'h77);
    o_wr_err = 1; o_wr_ack = 1; step(); o_wr_err = 0; o_wr_ack = 0;
    rd(16'h0005, d); chk("pusherr.status", d, 32'h07);
    rd(16'h0001, d); chk("pusherr.irq", d, 32'h1);
    wr(16'h0000, 32'h2);
    rd(16'h0005, d); chk("pusherr.sclr", d, 32'h0);
    rd(16'h0001, d); chk("pusherr.irq_clr", d, 32'h0);

    // Main compute flow
    wr(16'h0002, 32'h1);
    instruction_empty = 0;
    wr(16'h0000, 32'h1);
    chk("run.alu_begin", {31'b0, alu_begin}, 1);
    rd(16'h0005, d); chk("run.status_exec", d, 32'h01);
    wr(16'h0000, 32'h1);
    chk("run.start_in_exec", {31'b0, alu_begin}, 1);
    alu_done = 1; step(); alu_done = 0;
    chk("run.begin_drop", {31'b0, alu_begin}, 0);
    chk("run.r_pop", {31'b0, r_pop}, 1);
    r_dout = 32'hBAD0BAD0;
    step();
    chk("run.r_pop_pulse", {31'b0, r_pop}, 0);
    rd(16'h0004, d); chk("run.result_hold", d, 32'h0);
    r_dout = 32'h55; r_rd_ack = 1; step(); r_rd_ack = 0;
    chk("run.s_interrupt", {31'b0, s_interrupt}, 1);
    rd(16'h0004, d); chk("run.result", d, 32'h55);
    rd(16'h0005, d); chk("run.status_done", d, 32'h02);
    wr(16'h0001, 32'h1);
    chk("run.w1c", {31'b0, s_interrupt}, 0);

    // Start with empty instruction FIFO
    instruction_empty = 1;
    wr(16'h0000, 32'h1);
    chk("empty.alu_begin", {31'b0, alu_begin}, 0);
    chk("empty.s_interrupt", {31'b0, s_interrupt}, 1);
    rd(16'h0005, d); chk("empty.status", d, 32'h03);
    wr(16'h0000, 32'h1);
    rd(16'h0005, d); chk("empty.fault_sticks", d, 32'h03);
    wr(16'h0000, 32'h2);
    chk("empty.sclr_irq", {31'b0, s_interrupt}, 0);
    rd(16'h0005, d); chk("empty.sclr", d, 32'h0);
    instruction_empty = 0;

    // Hardware set beats W1C in the same cycle
    wr(16'h0000, 32'h1);
    alu_done = 1; step(); alu_done = 0;
    r_dout = 32'h99; r_rd_ack = 1; wr(16'h0001, 32'h1); r_rd_ack = 0;
    chk("race.s_interrupt", {31'b0, s_interrupt}, 1);
    rd(16'h0001, d); chk("race.irq", d, 32'h1);
    wr(16'h0001, 32'h1);
    chk("race.w1c", {31'b0, s_interrupt}, 0);
    m_result = 32'h99;

    // Randomized operand traffic and compute transactions vs model
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        int idx; logic [31:0] v;
        idx = $urandom_range(0, 31); v = $urandom;
        wr(16'h0010 + 16'(idx), v);
        chk("rnd.we", {31'b0, we}, (idx < 16) ? 32'h1 : 32'h0);
        if (idx < 16) begin
          chk("rnd.wAddr", {28'b0, wAddr}, 32'(idx));
          chk("rnd.wData", wData, v);
          m_opr[idx] = v;
        end
      end else if (op == 1) begin
        int idx;
        idx = $urandom_range(0, 31);
        rd(16'h0010 + 16'(idx), d);
        chk("rnd.rd", d, (idx < 16) ? m_opr[idx] : 32'h0);
      end else begin
        int dl, wt; logic [31:0] v; logic err;
        dl = $urandom_range(0, 5); wt = $urandom_range(0, 3);
        v = $urandom; err = ($urandom_range(0, 3) == 0);
        wr(16'h0000, 32'h1);
        chk("rnd.begin", {31'b0, alu_begin}, 1);
        repeat (dl) step();
        chk("rnd.begin_held", {31'b0, alu_begin}, 1);
        alu_done = 1; step(); alu_done = 0;
        chk("rnd.r_pop", {31'b0, r_pop}, 1);
        r_dout = $urandom;
        repeat (wt) step();
        rd(16'h0004, d); chk("rnd.result_hold", d, m_result);
        if (err) begin
          r_rd_err = 1; step(); r_rd_err = 0;
          rd(16'h0005, d); chk("rnd.poperr_status", d, 32'h0B);
          wr(16'h0000, 32'h2);
          rd(16'h0005, d); chk("rnd.poperr_sclr", d, 32'h0);
        end else begin
          r_dout = v; r_rd_ack = 1; step(); r_rd_ack = 0;
          m_result = v;
          chk("rnd.s_interrupt", {31'b0, s_interrupt}, 1);
          rd(16'h0005, d); chk("rnd.status_done", d, 32'h02);
          rd(16'h0004, d); chk("rnd.result", d, m_result);
          wr(16'h0001, 32'h1);
          chk("rnd.w1c", {31'b0, s_interrupt}, 0);
        end
      end
    end

    // EXEC without alu_done
    wr(16'h0000, 32'h1);
`ifdef ALU_TIMEOUT_EN
    repeat (7) step();
    chk("tmo.before", {31'b0, alu_begin}, 1);
    step();
    chk("tmo.after", {31'b0, alu_begin}, 0);
    chk("tmo.s_interrupt", {31'b0, s_interrupt}, 1);
    rd(16'h0005, d); chk("tmo.status", d, 32'h23);
`else
    repeat (100) step();
    chk("notmo.alu_begin", {31'b0, alu_begin}, 1);
    rd(16'h0005, d); chk("notmo.status", d, 32'h01);
`endif
    wr(16'h0000, 32'h2);
    chk("tmo.sclr_begin", {31'b0, alu_begin}, 0);
    rd(16'h0005, d); chk("tmo.sclr_status", d, 32'h0);

    // Synchronous reset in the middle of both handshakes
    wr(16'h0003, 32'h5);
    wr(16'h0000, 32'h1);
    chk("rst_mid.begin", {31'b0, alu_begin}, 1);
    reset = 1; step();
    chk_all_zero("rst_mid");
    reset = 0;
    o_wr_ack = 1; alu_done = 1; step(); o_wr_ack = 0; alu_done = 0;
    chk("rst_mid.no_pop", {31'b0, r_pop}, 0);
    chk("rst_mid.no_begin", {31'b0, alu_begin}, 0);
    rd(16'h0005, d); chk("rst_mid.status", d, 32'h0);
    wr(16'h0003, 32'h6);
    chk("rst_mid.push_ok", {31'b0, o_push}, 1);
    chk("rst_mid.o_din", o_din, 32'h6);
    o_wr_ack = 1; step(); o_wr_ack = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
